pwm_scheduler_3lfcc: RTL and testbench
======================================

# pwm_scheduler_3lfcc

Phase-shifted PWM scheduler for the 3-level flying-capacitor converter. It consumes the triangular carrier and the peak/valley event from the carrier generator, derives the 180°-shifted carrier, and compares both carriers against a duty command. It latches duty updates only at carrier peaks and valleys, inserts dead time on both switch legs, and schedules the ADC trigger. It sits between the carrier generator and the gate-driver pins; the control loop feeds it duty commands.

## Interface
- `WIDTH_TRIANG`, 7: carrier and duty width; carrier maximum `MAX = 2^WIDTH_TRIANG - 1`.
- `DEADTIME`, 4: dead-time length in clk cycles, must be ≥1.
- `DT_W`, 4: dead-time counter width, must satisfy `2^DT_W > DEADTIME`.
- `clk`  in  1  single clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `count`  in  WIDTH_TRIANG  carrier value from the triangular generator.
- `XADC_Event`  in  1  carrier peak/valley pulse from the generator.
- `enable`  in  1  level request to run the modulator.
- `fault`  in  1  external trip; all gates off.
- `duty_in`  in  WIDTH_TRIANG  duty command.
- `duty_valid`  in  1  duty command valid.
- `duty_ready`  out  1  pending slot empty.
- `gate_a_hi`, `gate_a_lo`  out  1 each  leg A complementary gates (0° carrier).
- `gate_b_hi`, `gate_b_lo`  out  1 each  leg B complementary gates (180° carrier).
- `adc_trig`  out  1  one-cycle ADC start pulse.
- `adc_phase`  out  1  0 = trigger at valley, 1 = trigger at peak.
- `running`  out  1  FSM in RUN.
- `fault_latched`  out  1  FSM in FAULT.

## Operation
- **Reset values.** Every output is 0 except `duty_ready`, which is 1. The pending and active duty registers are 0, both dead-time counters are 0, and the FSM is in IDLE.
- **FSM states.** IDLE, ARM, RUN, FAULT.
  - IDLE → ARM when `enable` = 1.
  - ARM → RUN on `XADC_Event` with `count == 0` (valley only). Peak events are ignored in ARM.
  - RUN → IDLE when `enable` = 0.
  - Any state → FAULT when `fault` = 1. Fault has priority over every other transition.
  - FAULT → IDLE only when `fault` = 0 and `enable` = 0.
- **Duty handshake.**
  - A command is accepted when `duty_valid && duty_ready`; it loads the pending register and sets the pending flag.
  - `duty_ready = !pending`.
  - On `XADC_Event` in RUN or ARM with the pending flag set: active ← pending, and the flag clears.
  - A command accepted in the same cycle as an event does not transfer in that cycle; it waits for the next event.
  - `duty_valid` held high while `duty_ready` = 0 is stalled without loss.
  - Pending and active duty are retained across IDLE and FAULT.
- **Carrier compare** (registered into `cmp_a`/`cmp_b`, RUN only, otherwise 0).
  - `cmp_a = duty_active > count`.
  - `cmp_b = duty_active > (MAX - count)`, computed at WIDTH_TRIANG width with no overflow.
  - Duty 0 gives `cmp` always 0; duty MAX gives `cmp` = 0 only at the carrier extreme.
- **Dead time** (per leg).
  - The target is `hi` if `cmp` = 1, else `lo`.
  - On a target change, both gates drop low and the counter loads DEADTIME. When the counter reaches 0, the target gate goes high.
  - A target change during dead time restarts the counter and uses the newest target.
  - `hi` and `lo` are never both 1 under any input sequence.
- **ADC scheduling.** `adc_trig` pulses one cycle after each `XADC_Event` in RUN. `adc_phase` is registered with it and equals `count == MAX` at the event.
- **Outside RUN.** In IDLE, ARM and FAULT all gates are 0 and the counters are cleared. On entry to RUN, the first gate turn-on waits a full DEADTIME.

## Timing
- `count` / `duty_active` sampled at edge n → `cmp` valid after edge n+1.
- `cmp` change at edge n+1: the old gate goes low at edge n+2, and the new gate goes high at edge n+2+DEADTIME.
- `fault` sampled at edge n → all gates 0 after edge n+1. This is one cycle, with no dead-time wait.
- `XADC_Event` at edge n → new `duty_active` after edge n+1, `adc_trig` high for the cycle following edge n+1.
- Reset asserted mid-operation forces reset values asynchronously, with no dead-time sequencing.

## Structure
- A shared package `lfcc_pkg` holds:
  - the FSM state enum (IDLE, ARM, RUN, FAULT);
  - `CARRIER_MAX` derived from WIDTH_TRIANG;
  - the default DEADTIME.
- One sub-module, `deadtime_inserter`, with inputs `clk`, `rst`, `clr`, `target` and outputs `hi`, `lo`. It is instantiated twice, once for leg A and once for leg B.
- The top level holds the FSM, the duty handshake registers, the comparators and the ADC scheduler.

## Test plan
- **Arm and run.** Reset, `enable` = 1, duty 64 → no gates until the first valley event. Then `gate_a_hi` is high while `count` < 64 (minus dead time), and leg B is its mirror about `count` = 63.5.
- **Shadow update.** Accept duty 32 mid-ramp → active duty changes only one cycle after the next event. A second `duty_valid` is stalled (`duty_ready` = 0) until that event.
- **Dead-time integrity.** Random duty, DEADTIME = 4 → each transition shows exactly 4 cycles with both gates low. `hi & lo` is never 1.
- **Fault.** Assert `fault` while `gate_a_hi` = 1 → all gates are 0 one cycle later and `fault_latched` = 1. The block stays in FAULT until both `fault` = 0 and `enable` = 0.
- **ADC.** Over one full carrier period in RUN → exactly two `adc_trig` pulses, with `adc_phase` = 1 at the peak and 0 at the valley.
- **Extremes and reset.** Duty 0 → `gate_*_lo` stays on continuously. Asserting `rst` mid-RUN → every output returns to its reset value immediately.

Source files
------------

// File: rtl/pwm_scheduler_3lfcc_pkg.sv
// lfcc_pkg: shared FSM state type and carrier/dead-time constants for the 3-level FC PWM scheduler
package lfcc_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN, FAULT} state_t;
  localparam int WIDTH_TRIANG_DEF = 7;
  localparam int DEADTIME_DEF = 4;
  function automatic int carrier_max(input int w);
    return (1 << w) - 1;
  endfunction
  localparam int CARRIER_MAX = carrier_max(WIDTH_TRIANG_DEF);
endpackage

// File: rtl/pwm_scheduler_3lfcc_if.sv
// pwm_scheduler_3lfcc_if: duty command valid/ready handshake from the control loop
interface pwm_scheduler_3lfcc_if #(parameter int W = 7);
  logic [W-1:0] duty_in;
  logic duty_valid;
  logic duty_ready;
  modport master(output duty_in, output duty_valid, input duty_ready);
  modport slave(input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_scheduler_3lfcc_deadtime.sv
// deadtime_inserter: complementary gate pair that waits DEADTIME cycles with both gates low on every target change
module deadtime_inserter
  import lfcc_pkg::*;
#(
  parameter int DEADTIME = DEADTIME_DEF,
  parameter int DT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic target,
  output logic hi,
  output logic lo
);
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic tgt_q, tgt_d, armed_q, armed_d, hi_q, hi_d, lo_q, lo_d;
  logic change, settled;
  // armed_q low after a clear forces the first target to be treated as a change
  always_comb begin
    change = !armed_q || (target != tgt_q);
    settled = !clr && !change && (cnt_q <= DT_W'(1));
    armed_d = !clr;
    tgt_d = clr ? 1'b0 : target;
    cnt_d = clr ? '0 : change ? DT_W'(DEADTIME) : (cnt_q > DT_W'(1)) ? cnt_q - DT_W'(1) : '0;
    hi_d = settled && tgt_q;
    lo_d = settled && !tgt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tgt_q <= 1'b0;
      armed_q <= 1'b0;
      hi_q <= 1'b0;
      lo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      armed_q <= armed_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: rtl/pwm_scheduler_3lfcc.sv
// pwm_scheduler_3lfcc: phase-shifted PWM with shadowed duty, dead time on two legs and ADC trigger scheduling
module pwm_scheduler_3lfcc
  import lfcc_pkg::*;
#(
  parameter int WIDTH_TRIANG = WIDTH_TRIANG_DEF,
  parameter int DEADTIME = DEADTIME_DEF,
  parameter int DT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH_TRIANG-1:0] count,
  input  logic XADC_Event,
  input  logic enable,
  input  logic fault,
  pwm_scheduler_3lfcc_if.slave duty,
  output logic gate_a_hi,
  output logic gate_a_lo,
  output logic gate_b_hi,
  output logic gate_b_lo,
  output logic adc_trig,
  output logic adc_phase,
  output logic running,
  output logic fault_latched
);
  localparam logic [WIDTH_TRIANG-1:0] MAX = WIDTH_TRIANG'(carrier_max(WIDTH_TRIANG));
  state_t state_q, state_d;
  logic [WIDTH_TRIANG-1:0] pend_q, pend_d, act_q, act_d;
  logic pflag_q, pflag_d, cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
  logic trig_q, trig_d, phase_q, phase_d, running_q, fault_latched_q;
  logic is_run, accept, xfer, clr;
  always_comb begin
    is_run = state_q == RUN;
    accept = duty.duty_valid && !pflag_q;
    xfer = XADC_Event && pflag_q && (is_run || state_q == ARM);
    pend_d = accept ? duty.duty_in : pend_q;
    pflag_d = xfer ? 1'b0 : accept ? 1'b1 : pflag_q;
    act_d = xfer ? pend_q : act_q;
    cmp_a_d = is_run && (act_q > count);
    cmp_b_d = is_run && (act_q > (MAX - count));
    trig_d = is_run && XADC_Event;
    phase_d = trig_d ? (count == MAX) : phase_q;
    // a trip drops the gates on the very next edge, bypassing dead time
    clr = !is_run || fault;
    case (state_q)
      IDLE:    state_d = enable ? ARM : IDLE;
      ARM:     state_d = (XADC_Event && count == '0) ? RUN : ARM;
      RUN:     state_d = enable ? RUN : IDLE;
      FAULT:   state_d = enable ? FAULT : IDLE;
      default: state_d = IDLE;
    endcase
    state_d = fault ? FAULT : state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      running_q <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q <= state_d;
      running_q <= state_d == RUN;
      fault_latched_q <= state_d == FAULT;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      act_q <= '0;
      pflag_q <= 1'b0;
      cmp_a_q <= 1'b0;
      cmp_b_q <= 1'b0;
      trig_q <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q <= act_d;
      pflag_q <= pflag_d;
      cmp_a_q <= cmp_a_d;
      cmp_b_q <= cmp_b_d;
      trig_q <= trig_d;
      phase_q <= phase_d;
    end
  end
  deadtime_inserter #(.DEADTIME(DEADTIME), .DT_W(DT_W)) u_leg_a (
    .clk(clk), .rst(rst), .clr(clr), .target(cmp_a_q), .hi(gate_a_hi), .lo(gate_a_lo)
  );
  deadtime_inserter #(.DEADTIME(DEADTIME), .DT_W(DT_W)) u_leg_b (
    .clk(clk), .rst(rst), .clr(clr), .target(cmp_b_q), .hi(gate_b_hi), .lo(gate_b_lo)
  );
  assign duty.duty_ready = !pflag_q;
  assign adc_trig = trig_q;
  assign adc_phase = phase_q;
  assign running = running_q;
  assign fault_latched = fault_latched_q;
endmodule

// File: tb/tb_pwm_scheduler_3lfcc.sv
// tb_pwm_scheduler_3lfcc: randomized scoreboard bench with a sliding-window dead-time reference model
module tb_pwm_scheduler_3lfcc;
  localparam int W = 7, DT = 4, MAXV = 127;
  typedef struct packed {logic ahi, alo, bhi, blo, run, flt, rdy, trig;} exp_t;
  logic clk = 0, rst = 1, XADC_Event = 0, enable = 0, fault = 0;
  logic [W-1:0] count = '0;
  logic gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo, adc_trig, adc_phase, running, fault_latched;
  int checks = 0, failures = 0, trig_cnt = 0;
  exp_t exp_q[$];
  bit adc_q[$];
  int m_st, m_pend, m_act;
  bit m_pf, m_ca, m_cb, last_acc, up = 1;
  bit ha[$], hb[$], hc[$];

  pwm_scheduler_3lfcc_if #(.W(W)) dif ();
  pwm_scheduler_3lfcc #(.WIDTH_TRIANG(W), .DEADTIME(DT), .DT_W(4)) dut (
    .clk(clk), .rst(rst), .count(count), .XADC_Event(XADC_Event), .enable(enable), .fault(fault),
    .duty(dif), .gate_a_hi(gate_a_hi), .gate_a_lo(gate_a_lo), .gate_b_hi(gate_b_hi),
    .gate_b_lo(gate_b_lo), .adc_trig(adc_trig), .adc_phase(adc_phase), .running(running),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // expected outputs after the coming edge, from the current inputs and model state
  task automatic cyc();
    exp_t e;
    bit adc_ev, ph, run, clrn, ah, al, bh, bl, acc, xf;
    int nst;
    e = '0;
    adc_ev = 0;
    ph = 0;
    if (rst) begin
      m_st = 0; m_pend = 0; m_act = 0; m_pf = 0; m_ca = 0; m_cb = 0; last_acc = 0;
      ha.delete(); hb.delete(); hc.delete();
      e.rdy = 1;
    end else begin
      run = m_st == 2;
      clrn = !run || fault;
      ha.push_back(m_ca); hb.push_back(m_cb); hc.push_back(clrn);
      if (ha.size() > DT + 1) begin
        void'(ha.pop_front()); void'(hb.pop_front()); void'(hc.pop_front());
      end
      ah = ha.size() == DT + 1; al = ah; bh = ah; bl = ah;
      for (int i = 0; i < ha.size(); i++) begin
        ah &= ha[i]; al &= !ha[i]; bh &= hb[i]; bl &= !hb[i];
        if (hc[i]) begin ah = 0; al = 0; bh = 0; bl = 0; end
      end
      m_ca = run && (m_act > int'(count));
      m_cb = run && (m_act > MAXV - int'(count));
      acc = dif.duty_valid && !m_pf;
      xf = XADC_Event && m_pf && (m_st == 1 || m_st == 2);
      if (xf) begin m_act = m_pend; m_pf = 0; end
      if (acc) begin m_pend = int'(dif.duty_in); m_pf = 1; end
      last_acc = acc;
      adc_ev = run && XADC_Event;
      ph = int'(count) == MAXV;
      if (fault) nst = 3;
      else if (m_st == 0) nst = enable ? 1 : 0;
      else if (m_st == 1) nst = (XADC_Event && count == 0) ? 2 : 1;
      else if (m_st == 2) nst = enable ? 2 : 0;
      else nst = enable ? 3 : 0;
      m_st = nst;
      e.ahi = ah; e.alo = al; e.bhi = bh; e.blo = bl;
      e.run = nst == 2; e.flt = nst == 3; e.rdy = !m_pf; e.trig = adc_ev;
    end
    @(posedge clk);
    exp_q.push_back(e);
    if (adc_ev) adc_q.push_back(ph);
    #1;
  endtask

  task automatic step();
    cyc();
    if (up) begin
      if (int'(count) == MAXV - 1) up = 0;
      count = count + 1'b1;
    end else begin
      if (count == 1) up = 1;
      count = count - 1'b1;
    end
    XADC_Event = (count == 0) || (int'(count) == MAXV);
  endtask

  task automatic send(input int d);
    int n;
    dif.duty_in = W'(d);
    dif.duty_valid = 1;
    n = 0;
    do begin step(); n++; end while (!last_acc && n < 400);
    dif.duty_valid = 0;
    chk("duty_accept_timeout", int'(last_acc), 1);
  endtask

  always @(negedge clk) begin
    exp_t a, e;
    bit p;
    a.ahi = gate_a_hi; a.alo = gate_a_lo; a.bhi = gate_b_hi; a.blo = gate_b_lo;
    a.run = running; a.flt = fault_latched; a.rdy = dif.duty_ready; a.trig = adc_trig;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs got=%b want=%b (ahi alo bhi blo run flt rdy trig)", a, e);
      end
    end
    if (!rst) begin
      checks++;
      if ((gate_a_hi && gate_a_lo) || (gate_b_hi && gate_b_lo)) begin
        failures++;
        $display("FAIL shoot_through a=%b%b b=%b%b want no pair both 1", gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo);
      end
    end
    if (adc_trig === 1'b1) begin
      trig_cnt++;
      checks++;
      if (adc_q.size() == 0) begin
        failures++;
        $display("FAIL adc_trig got=1 want=0 (no event pending)");
      end else begin
        p = adc_q.pop_front();
        if (adc_phase !== p) begin
          failures++;
          $display("FAIL adc_phase got=%b want=%b", adc_phase, p);
        end
      end
    end
  end

  initial begin
    int n, r;
    dif.duty_in = '0;
    dif.duty_valid = 0;
    repeat (3) step();
    chk("reset_outputs", int'({gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo, adc_trig, adc_phase,
                               running, fault_latched, dif.duty_ready}), 1);
    rst = 0;
    enable = 1;
    send(64);
    repeat (760) step();
    chk("running_after_arm", int'(running), 1);
    trig_cnt = 0;
    repeat (254) step();
    chk("adc_pulses_per_period", trig_cnt, 2);
    repeat (40) step();
    send(32);
    send(50);
    repeat (300) step();
    repeat (1500) begin
      if (!dif.duty_valid && $urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 9);
        dif.duty_in = (r == 0) ? '0 : (r == 1) ? W'(MAXV) : W'($urandom_range(0, MAXV));
        dif.duty_valid = 1;
      end
      step();
      if (last_acc) dif.duty_valid = 0;
    end
    dif.duty_valid = 0;
    send(64);
    n = 0;
    while (gate_a_hi !== 1'b1 && n < 600) begin step(); n++; end
    chk("gate_a_hi_seen", int'(gate_a_hi), 1);
    fault = 1;
    step();
    chk("fault_gates_off", int'({gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo}), 0);
    chk("fault_latched", int'(fault_latched), 1);
    repeat (3) step();
    fault = 0;
    repeat (5) step();
    chk("fault_held_enable", int'(fault_latched), 1);
    enable = 0;
    repeat (2) step();
    chk("fault_cleared", int'({fault_latched, running}), 0);
    enable = 1;
    send(0);
    repeat (600) step();
    chk("duty0_lo_on", int'({gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo}), 5);
    send(100);
    repeat (300) step();
    chk("running_before_rst", int'(running), 1);
    #5;
    rst = 1;
    #1;
    chk("async_reset_outputs", int'({gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo, adc_trig, adc_phase,
                                     running, fault_latched, dif.duty_ready}), 1);
    repeat (2) step();
    rst = 0;
    repeat (20) step();
    step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
